// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and helpers for the multi-channel servo pulse generator
package servo_pkg;

    localparam int POS_W = 8;
    localparam logic [POS_W-1:0] CENTER_POS = 8'd128;

    function automatic logic [31:0] pulse_width(input logic [POS_W-1:0] pos,
                                                input int unsigned min_pulse,
                                                input int unsigned step_cycles);
        return min_pulse + 32'(pos) * step_cycles;
    endfunction

    function automatic int cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// rtl/servo_pwm_multi_if.sv - position write port of the multi-channel servo pulse generator
interface servo_pwm_multi_if;
    import servo_pkg::*;

    logic             wr_valid;
    logic             wr_ready;
    logic [3:0]       wr_chan;
    logic [POS_W-1:0] wr_pos;
    logic             wr_err;

    modport master (output wr_valid, wr_chan, wr_pos, input wr_ready, wr_err);
    modport slave  (input wr_valid, wr_chan, wr_pos, output wr_ready, wr_err);

endinterface

// File: rtl/servo_pwm_channel.sv
// rtl/servo_pwm_channel.sv - one servo channel: target/applied position, slew limiter, width latch, output register
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int CW          = 18,
    parameter int MIN_PULSE   = 10000,
    parameter int STEP_CYCLES = 40,
    parameter int SLEW_STEP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CW-1:0]    count,
    input  logic             frame_begin,
    input  logic             slew,
    input  logic             load,
    input  logic [POS_W-1:0] load_pos,
    input  logic             ena,
    input  logic             chan_en,
    output logic             pwm
);

    localparam int STEP_CLAMP = (SLEW_STEP > 255) ? 255 : SLEW_STEP;
    localparam logic [POS_W-1:0] STEP = POS_W'(STEP_CLAMP);

    logic [POS_W-1:0] target;
    logic [POS_W-1:0] applied;
    logic [POS_W-1:0] applied_next;
    logic [31:0]      width_q;
    logic [31:0]      width_cur;

    // Differences are compared before stepping so the result never overshoots or wraps.
    always_comb begin
        applied_next = applied;
        if (SLEW_STEP == 0) begin
            applied_next = target;
        end else if (applied < target) begin
            applied_next = ((target - applied) > STEP) ? applied + STEP : target;
        end else if (applied > target) begin
            applied_next = ((applied - target) > STEP) ? applied - STEP : target;
        end
    end

    // The first cycle of a frame compares against the freshly computed width.
    assign width_cur = frame_begin ? pulse_width(applied, MIN_PULSE, STEP_CYCLES) : width_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            target  <= CENTER_POS;
            applied <= CENTER_POS;
            width_q <= pulse_width(CENTER_POS, MIN_PULSE, STEP_CYCLES);
            pwm     <= 1'b0;
        end else begin
            if (load) begin
                target <= load_pos;
            end
            if (slew) begin
                applied <= applied_next;
            end
            if (frame_begin) begin
                width_q <= width_cur;
            end
            pwm <= ena & chan_en & (32'(count) < width_cur);
        end
    end

endmodule

// File: rtl/servo_pwm_multi.sv
// rtl/servo_pwm_multi.sv - multi-channel servo pulse generator: shared frame counter, write handshake, channel array
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int FRAME_CYCLES = 200000,
    parameter int MIN_PULSE    = 10000,
    parameter int STEP_CYCLES  = 40,
    parameter int SLEW_STEP    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    input  logic [CHANNELS-1:0] chan_en,
    servo_pwm_multi_if.slave    wr,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                frame_start
);

    localparam int CW = cnt_width(FRAME_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("CHANNELS must be in 1..16");
    end
    if (MIN_PULSE + 255 * STEP_CYCLES >= FRAME_CYCLES) begin : g_bad_timing
        $error("widest pulse does not fit inside one frame");
    end

    logic [CW-1:0] count;
    logic          slew;
    logic          frame_begin;
    logic          accept;
    logic          chan_ok;

    assign slew        = ena && (count == LAST);
    assign frame_begin = ena && (count == '0);

    // Writes stall only on the slew cycle so a target never changes while it is being consumed.
    assign wr.wr_ready = !reset && !slew;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign chan_ok     = {1'b0, wr.wr_chan} < 5'(CHANNELS);

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            frame_start <= 1'b0;
            wr.wr_err   <= 1'b0;
        end else begin
            if (ena) begin
                count <= (count == LAST) ? '0 : count + CW'(1);
            end
            frame_start <= frame_begin;
            wr.wr_err   <= accept && !chan_ok;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        servo_pwm_channel #(
            .CW          (CW),
            .MIN_PULSE   (MIN_PULSE),
            .STEP_CYCLES (STEP_CYCLES),
            .SLEW_STEP   (SLEW_STEP)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .count       (count),
            .frame_begin (frame_begin),
            .slew        (slew),
            .load        (accept && chan_ok && (wr.wr_chan == 4'(i))),
            .load_pos    (wr.wr_pos),
            .ena         (ena),
            .chan_en     (chan_en[i]),
            .pwm         (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb/tb_servo_pwm_multi.sv - scoreboard bench for servo_pwm_multi: slewing and jumping builds side by side
module tb_servo_pwm_multi;

    localparam int CH = 4;
    localparam int FC = 1000;
    localparam int MP = 100;
    localparam int SC = 2;
    localparam int SS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ena;
    logic [CH-1:0] chan_en;
    logic [CH-1:0] pwm_a, pwm_b;
    logic          fs_a, fs_b;

    servo_pwm_multi_if wa ();
    servo_pwm_multi_if wb ();

    servo_pwm_multi #(.CHANNELS(CH), .FRAME_CYCLES(FC), .MIN_PULSE(MP),
                      .STEP_CYCLES(SC), .SLEW_STEP(SS)) dut (
        .clk(clk), .reset(reset), .ena(ena), .chan_en(chan_en),
        .wr(wa.slave), .pwm_out(pwm_a), .frame_start(fs_a));

    servo_pwm_multi #(.CHANNELS(CH), .FRAME_CYCLES(FC), .MIN_PULSE(MP),
                      .STEP_CYCLES(SC), .SLEW_STEP(0)) dut_jump (
        .clk(clk), .reset(reset), .ena(ena), .chan_en(chan_en),
        .wr(wb.slave), .pwm_out(pwm_b), .frame_start(fs_b));

    always #5 clk = ~clk;

    typedef struct { int dut; int ch; int width; } exp_t;
    typedef struct { int s; logic [3:0] ch; logic [7:0] pos; } wr_t;

    exp_t sb[$];
    wr_t  wq[$];
    int   app_a[CH], app_b[CH], tgt[CH];
    int   n_assert = 0;
    int   n_fail   = 0;
    logic err_pend = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int slew_f(input int app, input int t, input int step);
        if (step == 0) return t;
        if (app < t) return (t - app > step) ? app + step : t;
        if (app > t) return (app - t > step) ? app - step : t;
        return app;
    endfunction

    task automatic add_wr(input int s, input logic [3:0] ch, input logic [7:0] pos);
        wr_t w;
        w.s = s; w.ch = ch; w.pos = pos;
        wq.push_back(w);
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            app_a[c] = 128; app_b[c] = 128; tgt[c] = 128;
        end
    endtask

    task automatic wait_fs(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (fs_a !== 1'b1 && t < 3000);
        check({name, "_frame_start"}, 32'(fs_a), 32'd1);
        check({name, "_frame_period"}, t, 1);
    endtask

    // One frame, starting at the negedge where frame_start is seen; s counts samples, cm models the counter.
    task automatic measure(input string name, input int frz_at, input int frz_len, input bit chk_ready);
        int   hi_a[CH], hi_b[CH];
        int   s, cm, frz_left, bad, fs_cnt, err_hits, err_exp;
        bit   froze, done, present;
        logic r998, r999, r0;
        exp_t e;
        wait_fs(name);
        for (int c = 0; c < CH; c++) begin
            e.ch = c;
            e.dut = 0; e.width = chan_en[c] ? MP + SC * app_a[c] : 0; sb.push_back(e);
            e.dut = 1; e.width = chan_en[c] ? MP + SC * app_b[c] : 0; sb.push_back(e);
            hi_a[c] = 0; hi_b[c] = 0;
        end
        check({name, "_rise_a"}, 32'(pwm_a), 32'(chan_en));
        check({name, "_rise_b"}, 32'(pwm_b), 32'(chan_en));
        s = 0; cm = 1; frz_left = 0; bad = 0; fs_cnt = 0; err_hits = 0; err_exp = 0;
        froze = 0; done = 0; r998 = 1'bx; r999 = 1'bx; r0 = 1'bx;
        while (!done) begin
            for (int c = 0; c < CH; c++) begin
                if (pwm_a[c] === 1'b1) hi_a[c]++;
                if (pwm_b[c] === 1'b1) hi_b[c]++;
            end
            if (fs_a === 1'b1) fs_cnt++;
            if (fs_b !== fs_a) bad++;
            if (wa.wr_err !== err_pend || wb.wr_err !== err_pend) bad++;
            if (wa.wr_err === 1'b1) err_hits++;
            err_pend = 1'b0;
            if (frz_left > 0) begin
                if (pwm_a !== '0 || pwm_b !== '0) bad++;
                frz_left--;
                if (frz_left == 0) ena = 1'b1;
            end
            if (frz_at >= 0 && cm == frz_at && !froze) begin
                ena = 1'b0; frz_left = frz_len; froze = 1;
            end
            present = (wq.size() > 0) && (wq[0].s <= s);
            wa.wr_valid = present; wb.wr_valid = present;
            if (present) begin
                wa.wr_chan = wq[0].ch; wb.wr_chan = wq[0].ch;
                wa.wr_pos  = wq[0].pos; wb.wr_pos = wq[0].pos;
            end
            if (wb.wr_ready !== wa.wr_ready) bad++;
            if (cm == FC - 2) r998 = wa.wr_ready;
            if (cm == FC - 1) r999 = wa.wr_ready;
            if (cm == 0) r0 = wa.wr_ready;
            if (present && wa.wr_ready === 1'b1) begin
                if (wq[0].ch < CH) tgt[wq[0].ch] = wq[0].pos;
                else begin err_pend = 1'b1; err_exp++; end
                void'(wq.pop_front());
            end
            if (ena && cm == FC - 1) begin
                for (int c = 0; c < CH; c++) begin
                    app_a[c] = slew_f(app_a[c], tgt[c], SS);
                    app_b[c] = slew_f(app_b[c], tgt[c], 0);
                end
            end
            s++;
            if (ena) begin
                if (cm == 0) done = 1;
                else begin
                    cm = (cm == FC - 1) ? 0 : cm + 1;
                    @(negedge clk);
                end
            end else begin
                @(negedge clk);
            end
        end
        check({name, "_frame_start_count"}, fs_cnt, 1);
        check({name, "_cycle_errors"}, bad, 0);
        check({name, "_wr_err_pulses"}, err_hits, err_exp);
        if (chk_ready) begin
            check({name, "_ready_at_998"}, 32'(r998), 32'd1);
            check({name, "_ready_at_999"}, 32'(r999), 32'd0);
            check({name, "_ready_at_0"}, 32'(r0), 32'd1);
        end
        for (int k = 0; k < 2 * CH; k++) begin
            e = sb.pop_front();
            check($sformatf("%s_d%0d_ch%0d_width", name, e.dut, e.ch),
                  (e.dut == 0) ? hi_a[e.ch] : hi_b[e.ch], e.width);
        end
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; chan_en = '1;
        wa.wr_valid = 1'b0; wa.wr_chan = '0; wa.wr_pos = '0;
        wb.wr_valid = 1'b0; wb.wr_chan = '0; wb.wr_pos = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_pwm_a", 32'(pwm_a), 32'd0);
        check("reset_pwm_b", 32'(pwm_b), 32'd0);
        check("reset_frame_start", 32'(fs_a), 32'd0);
        check("reset_wr_ready", 32'(wa.wr_ready), 32'd0);
        check("reset_wr_err", 32'(wa.wr_err), 32'd0);
        reset = 1'b0; ena = 1'b1;
        #1 check("ready_after_reset", 32'(wa.wr_ready), 32'd1);

        measure("f1_idle", -1, 0, 0);
        add_wr(300, 4'd1, 8'd255);
        add_wr(301, 4'd2, 8'd0);
        measure("f2_write", -1, 0, 0);
        for (int f = 3; f <= 35; f++) measure($sformatf("f%0d_slew", f), -1, 0, 0);

        add_wr(100, 4'd7, 8'd55);
        add_wr(400, 4'd3, 8'd10);
        add_wr(401, 4'd3, 8'd20);
        add_wr(997, 4'd0, 8'd200);
        add_wr(998, 4'd2, 8'd50);
        measure("f36_handshake", -1, 0, 1);

        chan_en = 4'h7;
        measure("f37_chan_en", -1, 0, 0);
        chan_en = 4'hF;
        measure("f38_freeze", 200, 50, 0);

        wait_fs("f39_pre_reset");
        repeat (149) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_pwm_a", 32'(pwm_a), 32'd0);
        check("midreset_pwm_b", 32'(pwm_b), 32'd0);
        check("midreset_frame_start", 32'(fs_a), 32'd0);
        check("midreset_wr_ready", 32'(wa.wr_ready), 32'd0);
        reset = 1'b0;
        model_reset();
        measure("f40_post_reset", -1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
